scroll_parallax: RTL and testbench
==================================

Name: scroll_parallax

Overview:
- Multi-layer successor to the single-layer horizontal scroll generator.
- Produces LAYERS wrapped x-positions for the cactus/floor/background layers, driven from one shared speed ramp.
- The step interval shrinks on every step, saturating at a floor period, so the game speeds up to a capped maximum.
- Layer k advances once every 2^k steps, giving parallax; it sits between the game FSM (halt/clear) and the sprite renderers.

Parameters:
- POS_W, 11, width of each position.
- LAYERS, 3, number of position channels (1..8).
- PERIOD_W, 20, width of the period and cycle counters.
- START_PERIOD, 500000, step period loaded at reset/clear.
- MIN_PERIOD, 100000, floor the period saturates at; must satisfy 0 < MIN_PERIOD <= START_PERIOD.
- PERIOD_DEC, 4, amount the period is reduced by after each step.
- STEP, 2, pixels added per layer advance; must satisfy STEP < WRAP.
- WRAP, 1280, position modulus; must satisfy WRAP <= 2^POS_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- halt  in  1  freezes all state while 1.
- clear  in  1  synchronous restart to reset values; has priority over halt.
- pos  out  LAYERS*POS_W  packed positions; layer k is at bits [k*POS_W +: POS_W].
- tick  out  1  one-cycle pulse in the cycle the positions update.
- period  out  PERIOD_W  current step period.
- max_speed  out  1  high when period == MIN_PERIOD.

Behaviour:
- Reset (async, reset_n=0) and clear (sync, clear=1) produce identical state:
  - all pos = 0, tick = 0, period = START_PERIOD;
  - cycle counter cnt = 0, step counter sc = 0;
  - max_speed = (START_PERIOD == MIN_PERIOD).
- halt=1 with clear=0:
  - every register holds, including cnt and sc;
  - tick = 0 in that cycle.
- Running (halt=0, clear=0) while cnt != period:
  - cnt <= cnt + 1;
  - tick <= 0.
- Running when cnt == period, a step occurs:
  - cnt <= 0, tick <= 1, sc <= sc + 1 (sc is max(LAYERS-1,1) bits and wraps).
  - Layer k advances iff sc[k-1:0] == 0, using sc before its increment; layer 0 always advances.
  - Advance rule: n = pos_k + STEP, computed one bit wider than POS_W; pos_k <= (n >= WRAP) ? n - WRAP : n.
  - Period update: period <= (period >= MIN_PERIOD + PERIOD_DEC) ? period - PERIOD_DEC : MIN_PERIOD. Compute in PERIOD_W+1 bits so it never underflows.
- Step spacing: consecutive steps are exactly (old period + 1) running cycles apart.
- Latency: pos, tick, period and max_speed all change on the same clock edge; tick is registered, not combinational.
- max_speed is registered and follows the period register; once set it stays set until reset/clear.
- Simultaneous clear and halt: clear wins.
- Clear on a step cycle: clear wins; no advance occurs.
- halt asserted mid-interval: cnt resumes from its held value, so no cycles are lost or repeated.
- Reset mid-operation: all outputs go to reset values immediately (asynchronous), with no dependence on clk.

Test Plan:
Common bench parameters: LAYERS=3, START_PERIOD=9, MIN_PERIOD=5, PERIOD_DEC=2, STEP=2, WRAP=20, POS_W=5, PERIOD_W=8.
1. Reset pulse, then run -> immediately after reset: pos={0,0,0}, period=9, tick=0, max_speed=0. First tick on the 10th running cycle: pos(L0,L1,L2)=2,2,2, period=7.
2. Continue running -> second tick 8 cycles later: pos=4,2,2, period=5, max_speed=1. Third tick 6 cycles later: pos=6,4,2, period stays 5. Fourth tick: pos=8,4,2. Fifth tick: pos=10,6,4.
3. Wrap: run to 10 layer-0 advances -> L0 goes 18 to 0 (never outputs 20). With STEP=3, 18 -> 1.
4. Assert halt for 7 cycles, 3 cycles into an interval -> no tick and outputs frozen while halted; after release the tick arrives after the remaining period-2 cycles.
5. Assert clear and halt together mid-run, including on a step cycle -> next cycle pos={0,0,0}, period=9, max_speed=0, tick=0.
6. Drop reset_n asynchronously between clock edges during a run -> outputs reach reset values before the next edge; normal stepping resumes after release.

Source files
------------

// File: rtl/scroll_parallax.sv
// Multi-layer parallax scroll generator. A shared speed ramp steps every layer,
// and layer k advances once every 2^k steps.
module scroll_parallax #(
  parameter int unsigned POS_W        = 11,
  parameter int unsigned LAYERS       = 3,
  parameter int unsigned PERIOD_W     = 20,
  parameter int unsigned START_PERIOD = 500000,
  parameter int unsigned MIN_PERIOD   = 100000,
  parameter int unsigned PERIOD_DEC   = 4,
  parameter int unsigned STEP         = 2,
  parameter int unsigned WRAP         = 1280
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     halt,
  input  logic                     clear,
  output logic [LAYERS*POS_W-1:0]  pos,
  output logic                     tick,
  output logic [PERIOD_W-1:0]      period,
  output logic                     max_speed
);

  localparam int unsigned SC_W = (LAYERS > 1) ? LAYERS - 1 : 1;

  localparam logic [PERIOD_W-1:0] START_P    = PERIOD_W'(START_PERIOD);
  localparam logic [PERIOD_W-1:0] MIN_P      = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] DEC_P      = PERIOD_W'(PERIOD_DEC);
  localparam logic [PERIOD_W:0]   DEC_THRESH = (PERIOD_W+1)'(MIN_PERIOD) + (PERIOD_W+1)'(PERIOD_DEC);
  localparam logic [POS_W:0]      STEP_X     = (POS_W+1)'(STEP);
  localparam logic [POS_W:0]      WRAP_X     = (POS_W+1)'(WRAP);
  localparam logic                MAX_RST    = (START_PERIOD == MIN_PERIOD);

  logic [LAYERS-1:0][POS_W-1:0] r_pos;
  logic [PERIOD_W-1:0]          r_cnt;
  logic [PERIOD_W-1:0]          r_period;
  logic [SC_W-1:0]              r_sc;
  logic                         r_tick;
  logic                         r_max;

  logic [LAYERS-1:0][POS_W-1:0] w_pos_nxt;
  logic [POS_W:0]               w_sum;
  logic [PERIOD_W-1:0]          w_period_nxt;

  // Candidate positions for a step: layer k moves when the low k bits of sc are zero.
  always_comb begin
    w_pos_nxt = r_pos;
    w_sum     = '0;
    for (int k = 0; k < LAYERS; k++) begin
      if ((r_sc & SC_W'((32'd1 << k) - 32'd1)) == '0) begin
        w_sum        = {1'b0, r_pos[k]} + STEP_X;
        w_pos_nxt[k] = (w_sum >= WRAP_X) ? POS_W'(w_sum - WRAP_X) : POS_W'(w_sum);
      end
    end
  end

  // Speed ramp: shrink by PERIOD_DEC, saturating at MIN_PERIOD without underflow.
  always_comb begin
    w_period_nxt = MIN_P;
    if ({1'b0, r_period} >= DEC_THRESH) begin
      w_period_nxt = r_period - DEC_P;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pos    <= '0;
      r_cnt    <= '0;
      r_period <= START_P;
      r_sc     <= '0;
      r_tick   <= 1'b0;
      r_max    <= MAX_RST;
    end else if (clear) begin
      r_pos    <= '0;
      r_cnt    <= '0;
      r_period <= START_P;
      r_sc     <= '0;
      r_tick   <= 1'b0;
      r_max    <= MAX_RST;
    end else if (halt) begin
      r_tick <= 1'b0;
    end else if (r_cnt == r_period) begin
      r_pos    <= w_pos_nxt;
      r_cnt    <= '0;
      r_period <= w_period_nxt;
      r_sc     <= r_sc + SC_W'(1);
      r_tick   <= 1'b1;
      r_max    <= (w_period_nxt == MIN_P);
    end else begin
      r_cnt  <= r_cnt + PERIOD_W'(1);
      r_tick <= 1'b0;
    end
  end

  assign pos       = r_pos;
  assign tick      = r_tick;
  assign period    = r_period;
  assign max_speed = r_max;

endmodule

// File: tb/tb_scroll_parallax.sv
// Bench for scroll_parallax: table of expected step events fed through a
// scoreboard queue, plus hand sequences for halt, clear and async reset.
module tb_scroll_parallax;

  localparam int unsigned POS_W = 5;
  localparam int unsigned LAYERS = 3;
  localparam int unsigned PERIOD_W = 8;

  logic clk;
  logic reset_n;
  logic halt;
  logic clear;
  logic [LAYERS*POS_W-1:0] pos;
  logic                    tick;
  logic [PERIOD_W-1:0]     period;
  logic                    max_speed;
  logic [LAYERS*POS_W-1:0] pos3;
  logic                    tick3;
  logic [PERIOD_W-1:0]     period3;
  logic                    max3;

  scroll_parallax #(
    .POS_W(POS_W), .LAYERS(LAYERS), .PERIOD_W(PERIOD_W), .START_PERIOD(9),
    .MIN_PERIOD(5), .PERIOD_DEC(2), .STEP(2), .WRAP(20)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .halt(halt), .clear(clear),
    .pos(pos), .tick(tick), .period(period), .max_speed(max_speed)
  );

  scroll_parallax #(
    .POS_W(POS_W), .LAYERS(LAYERS), .PERIOD_W(PERIOD_W), .START_PERIOD(9),
    .MIN_PERIOD(5), .PERIOD_DEC(2), .STEP(3), .WRAP(20)
  ) u_dut3 (
    .clk(clk), .reset_n(reset_n), .halt(halt), .clear(clear),
    .pos(pos3), .tick(tick3), .period(period3), .max_speed(max3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int gap;
    int p0;
    int p1;
    int p2;
    int per;
    int mx;
    int s3;
  } vec_t;

  vec_t vecs[11];
  vec_t sb[$];
  int n_checks;
  int n_errors;

  function automatic int lay(input logic [LAYERS*POS_W-1:0] v, input int k);
    return int'((v >> (k * POS_W)) & 15'h1f);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, ".pos0"}, lay(pos, 0), 0);
    chk({name, ".pos1"}, lay(pos, 1), 0);
    chk({name, ".pos2"}, lay(pos, 2), 0);
    chk({name, ".period"}, int'(period), 9);
    chk({name, ".tick"}, int'(tick), 0);
    chk({name, ".max"}, int'(max_speed), 0);
  endtask

  // Wait (bounded) for the next tick, then compare against the oldest scoreboard entry.
  task automatic wait_tick(input string name);
    vec_t e;
    int c;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = sb.pop_front();
    c = 0;
    do begin
      @(posedge clk);
      #1;
      c++;
    end while (!tick && c < e.gap + 4);
    chk({name, ".gap"}, c, e.gap);
    chk({name, ".pos0"}, lay(pos, 0), e.p0);
    chk({name, ".pos1"}, lay(pos, 1), e.p1);
    chk({name, ".pos2"}, lay(pos, 2), e.p2);
    chk({name, ".period"}, int'(period), e.per);
    chk({name, ".max"}, int'(max_speed), e.mx);
    chk({name, ".s3pos0"}, lay(pos3, 0), e.s3);
    chk({name, ".s3tick"}, int'(tick3), 1);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    vecs[0]  = '{10,  2,  2, 2, 7, 0,  3};
    vecs[1]  = '{ 8,  4,  2, 2, 5, 1,  6};
    vecs[2]  = '{ 6,  6,  4, 2, 5, 1,  9};
    vecs[3]  = '{ 6,  8,  4, 2, 5, 1, 12};
    vecs[4]  = '{ 6, 10,  6, 4, 5, 1, 15};
    vecs[5]  = '{ 6, 12,  6, 4, 5, 1, 18};
    vecs[6]  = '{ 6, 14,  8, 4, 5, 1,  1};
    vecs[7]  = '{ 6, 16,  8, 4, 5, 1,  4};
    vecs[8]  = '{ 6, 18, 10, 6, 5, 1,  7};
    vecs[9]  = '{ 6,  0, 10, 6, 5, 1, 10};
    vecs[10] = '{ 6,  2, 12, 6, 5, 1, 13};

    reset_n = 1'b1;
    halt    = 1'b0;
    clear   = 1'b0;
    #2 reset_n = 1'b0;
    #1 chk_reset_state("async_reset");
    run_cycles(3);
    reset_n = 1'b1;
    chk_reset_state("post_reset");

    // Speed ramp, layer parallax and wrap
    for (int i = 0; i < 11; i++) begin
      sb.push_back(vecs[i]);
      wait_tick($sformatf("step%0d", i + 1));
      if (i == 0) begin
        run_cycles(1);
        chk("tick_pulse_width", int'(tick), 0);
        sb.push_back('{7, 4, 2, 2, 5, 1, 6});
        wait_tick("step2_after_pulse");
        i = 1;
      end
    end

    // Halt 7 cycles, 3 cycles into an interval
    run_cycles(3);
    halt = 1'b1;
    for (int i = 0; i < 7; i++) begin
      run_cycles(1);
      chk($sformatf("halt_tick%0d", i), int'(tick), 0);
    end
    chk("halt_pos0", lay(pos, 0), 2);
    chk("halt_period", int'(period), 5);
    halt = 1'b0;
    sb.push_back('{3, 4, 12, 6, 5, 1, 16});
    wait_tick("after_halt");

    // Clear together with halt mid-interval
    run_cycles(2);
    clear = 1'b1;
    halt  = 1'b1;
    run_cycles(1);
    clear = 1'b0;
    halt  = 1'b0;
    chk_reset_state("clear_halt");
    sb.push_back('{10, 2, 2, 2, 7, 0, 3});
    wait_tick("after_clear");

    // Clear landing exactly on a step cycle
    run_cycles(7);
    clear = 1'b1;
    halt  = 1'b1;
    run_cycles(1);
    clear = 1'b0;
    halt  = 1'b0;
    chk_reset_state("clear_on_step");

    // Async reset between edges mid-run
    sb.push_back('{10, 2, 2, 2, 7, 0, 3});
    wait_tick("pre_async");
    run_cycles(3);
    #2 reset_n = 1'b0;
    #1 chk_reset_state("async_mid");
    @(posedge clk);
    #1 reset_n = 1'b1;
    chk_reset_state("async_held");
    sb.push_back('{10, 2, 2, 2, 7, 0, 3});
    wait_tick("after_async");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
